// File: rtl/niosiisystem_led_pio_pkg.sv
// niosiisystem_led_pio_pkg: register map and reset constants for the LED output PIO.
package niosiisystem_led_pio_pkg;
   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_MASK   = 2'd1;
   localparam logic [1:0] ADDR_PERIOD = 2'd2;
   localparam logic [1:0] ADDR_TOGGLE = 2'd3;
   localparam logic       PHASE_RESET = 1'b1;
endpackage

// File: rtl/niosiisystem_blink_timer.sv
// niosiisystem_blink_timer: reloadable down-counter whose phase flips every period+1 cycles.
module niosiisystem_blink_timer
   import niosiisystem_led_pio_pkg::*;
#(
   parameter int PERIOD_W = 26
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [PERIOD_W-1:0] period,
   input  logic                load,
   output logic                phase
);
   logic [PERIOD_W-1:0] cnt;
   // A load wins over expiry; an idle period of zero parks cnt at 0 with phase high.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         cnt   <= '0;
         phase <= PHASE_RESET;
      end else if (load || period == '0) begin
         cnt   <= period;
         phase <= PHASE_RESET;
      end else if (cnt == '0) begin
         cnt   <= period;
         phase <= ~phase;
      end else
         cnt <= cnt - PERIOD_W'(1);
endmodule

// File: rtl/niosiisystem_led_pio.sv
// niosiisystem_led_pio: Avalon-MM LED output PIO with per-bit hardware blink.
// NIOSIISYSTEM_LED_PIO_TOGGLE_EN enables the atomic XOR toggle register at address 3.
module niosiisystem_led_pio
   import niosiisystem_led_pio_pkg::*;
#(
   parameter int               WIDTH       = 10,
   parameter int               PERIOD_W    = 26,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);
   logic                wr;
   logic                period_wr;
   logic                data_we;
   logic                phase;
   logic [WIDTH-1:0]    data;
   logic [WIDTH-1:0]    data_nxt;
   logic [WIDTH-1:0]    mask;
   logic [PERIOD_W-1:0] period;
   logic [PERIOD_W-1:0] period_in;
   logic [31:0]         rd_mux;
   logic                unused_wd;

   assign wr        = chipselect & ~write_n;
   assign period_wr = wr && address == ADDR_PERIOD;
   assign period_in = period_wr ? writedata[PERIOD_W-1:0] : period;
   assign unused_wd = &{1'b0, writedata[31:PERIOD_W]};

`ifdef NIOSIISYSTEM_LED_PIO_TOGGLE_EN
   assign data_we  = wr && (address == ADDR_DATA || address == ADDR_TOGGLE);
   assign data_nxt = (address == ADDR_TOGGLE) ? data ^ writedata[WIDTH-1:0] : writedata[WIDTH-1:0];
`else
   assign data_we  = wr && address == ADDR_DATA;
   assign data_nxt = writedata[WIDTH-1:0];
`endif

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         data   <= RESET_VALUE;
         mask   <= '0;
         period <= '0;
      end else begin
         if (data_we) data <= data_nxt;
         if (wr && address == ADDR_MASK) mask <= writedata[WIDTH-1:0];
         if (period_wr) period <= writedata[PERIOD_W-1:0];
      end

   niosiisystem_blink_timer #(.PERIOD_W(PERIOD_W)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .period  (period_in),
      .load    (period_wr),
      .phase   (phase)
   );

   always_comb
      rd_mux = address == ADDR_DATA   ? 32'(data)   :
               address == ADDR_MASK   ? 32'(mask)   :
               address == ADDR_PERIOD ? 32'(period) : '0;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         readdata <= '0;
         out_port <= RESET_VALUE;
      end else begin
         readdata <= rd_mux;
         out_port <= data & (~mask | {WIDTH{phase}});
      end
endmodule

// File: tb/tb_niosiisystem_led_pio.sv
// tb_niosiisystem_led_pio: directed self-checking bench for the LED output PIO.
module tb_niosiisystem_led_pio;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [9:0]  out_port;
   int          tests = 0;
   int          fails = 0;

   niosiisystem_led_pio #(.WIDTH(10), .PERIOD_W(26), .RESET_VALUE(10'h2A0)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // called on a negedge; the write lands on the following posedge
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a);
      address = a;
      tick();
   endtask

   initial begin
      reset_n = 1'b0; address = 2'd1; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      repeat (3) tick();
      chk("rst_out", 32'(out_port), 32'h2A0);
      chk("rst_rd", readdata, 32'h0);
      reset_n = 1'b1;
      tick();
      chk("rd_mask_after_rst", readdata, 32'h0);
      chk("out_after_rst", 32'(out_port), 32'h2A0);

      wr(2'd0, 32'h3FF);
      chk("out_write_edge", 32'(out_port), 32'h2A0);
      tick();
      chk("out_after_write", 32'(out_port), 32'h3FF);
      rd(2'd0);
      chk("rd_data", readdata, 32'h3FF);

      address = 2'd0; writedata = '0; write_n = 1'b0; chipselect = 1'b0;
      tick();
      write_n = 1'b1;
      rd(2'd0);
      chk("no_write_wo_cs", readdata, 32'h3FF);

      wr(2'd1, 32'hFFFF_F00F);
      rd(2'd1);
      chk("rd_mask", readdata, 32'h00F);
      wr(2'd2, 32'd4);
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("blink4_%0d", k), 32'(out_port),
             (k >= 6 && (((k - 1) / 5) % 2 == 1)) ? 32'h3F0 : 32'h3FF);
         if (k < 15) tick();
      end

      wr(2'd2, 32'd0);
      chk("stop_edge", 32'(out_port), 32'h3F0);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk($sformatf("stopped_%0d", k), 32'(out_port), 32'h3FF);
      end
      rd(2'd2);
      chk("rd_period0", readdata, 32'h0);

      wr(2'd2, 32'd4);
      repeat (4) tick();
      wr(2'd2, 32'd9);
      for (int k = 5; k <= 16; k++) begin
         chk($sformatf("reload_%0d", k), 32'(out_port), (k == 16) ? 32'h3F0 : 32'h3FF);
         if (k < 16) tick();
      end
      rd(2'd2);
      chk("rd_period9", readdata, 32'd9);

      reset_n = 1'b0;
      #1;
      chk("async_rst_out", 32'(out_port), 32'h2A0);
      chk("async_rst_rd", readdata, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) tick();
      chk("no_blink_after_rst", 32'(out_port), 32'h2A0);

      wr(2'd0, 32'h155);
      wr(2'd3, 32'h3FF);
      rd(2'd0);
`ifdef NIOSIISYSTEM_LED_PIO_TOGGLE_EN
      chk("toggle_data", readdata, 32'h2AA);
`else
      chk("toggle_ignored", readdata, 32'h155);
`endif
      rd(2'd3);
      chk("rd_addr3", readdata, 32'h0);
      tick();
`ifdef NIOSIISYSTEM_LED_PIO_TOGGLE_EN
      chk("toggle_out", 32'(out_port), 32'h2AA);
`else
      chk("toggle_out", 32'(out_port), 32'h155);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
